// File: rtl/tristate_bus_ctrl.sv
// Tristate pad bus controller: sequences write (setup/strobe/hold) and read (strobe)
// cycles on an external bus, with a released-bus turnaround closing every transaction.
module tristate_bus_ctrl #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned TURN_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] pad_o,
  output logic       pad_t,
  input  logic [7:0] pad_i,
  output logic       bus_we_n,
  output logic       bus_re_n
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WSETUP  = 3'd1,
    WSTROBE = 3'd2,
    WHOLD   = 3'd3,
    RSTROBE = 3'd4,
    TURN    = 3'd5
  } state_t;

  // Counter is loaded with length-1 on phase entry and the phase ends when it hits 0.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_cyc;
  logic [7:0] pad_o_q, pad_o_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pad_t_q, pad_t_d;
  logic       we_n_q, we_n_d;
  logic       re_n_q, re_n_d;

  assign last_cyc = (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = last_cyc ? cnt_q : (cnt_q - 4'd1);
    pad_o_d = pad_o_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (rd_req) begin
          state_d = RSTROBE;
          cnt_d   = STROBE_LD;
        end else if (wr_req) begin
          state_d = WSETUP;
          cnt_d   = SETUP_LD;
          pad_o_d = wdata;
        end
      end
      WSETUP: if (last_cyc) begin
        state_d = WSTROBE;
        cnt_d   = STROBE_LD;
      end
      WSTROBE: if (last_cyc) begin
        state_d = WHOLD;
        cnt_d   = HOLD_LD;
      end
      WHOLD: if (last_cyc) begin
        state_d = TURN;
        cnt_d   = TURN_LD;
      end
      RSTROBE: if (last_cyc) begin
        state_d = TURN;
        cnt_d   = TURN_LD;
        rdata_d = pad_i;
      end
      TURN: if (last_cyc) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == TURN) && (state_q != TURN);
    pad_t_d = !((state_d == WSETUP) || (state_d == WSTROBE) || (state_d == WHOLD));
    we_n_d  = (state_d != WSTROBE);
    re_n_d  = (state_d != RSTROBE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pad_o_q <= 8'h00;
      rdata_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pad_t_q <= 1'b1;
      we_n_q  <= 1'b1;
      re_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pad_o_q <= pad_o_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pad_t_q <= pad_t_d;
      we_n_q  <= we_n_d;
      re_n_q  <= re_n_d;
    end
  end

  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pad_o    = pad_o_q;
  assign pad_t    = pad_t_q;
  assign bus_we_n = we_n_q;
  assign bus_re_n = re_n_q;

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Bench for tristate_bus_ctrl: table of transactions with a per-transaction scoreboard,
// bus-safety invariant monitor, and hand sequences for busy requests, turnaround and reset abort.
module tb_tristate_bus_ctrl;

  logic       clk;
  logic       reset;
  logic       wr_req;
  logic       rd_req;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic [7:0] pad_o;
  logic       pad_t;
  logic [7:0] pad_i;
  logic       bus_we_n;
  logic       bus_re_n;

  tristate_bus_ctrl dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .pad_o(pad_o), .pad_t(pad_t),
    .pad_i(pad_i), .bus_we_n(bus_we_n), .bus_re_n(bus_re_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rd;
    bit         wr;
    logic [7:0] wd;
    logic [7:0] pi;
    int         busy_cyc;
    int         we_low;
    int         re_low;
    int         pt0;
    int         done_cyc;
    logic [7:0] rdata_exp;
    logic [7:0] pado_exp;
  } vec_t;

  vec_t q[$];
  vec_t tbl[8];

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  // Monitor state
  bit         in_txn = 0;
  int         cyc, we_cnt, re_cnt, pt_cnt, done_cnt, done_at;
  logic [7:0] rd_at_done, po_at_done;
  int         gcyc = 0;
  int         re_gap = 100;
  int         re_rise_cyc = 0;
  int         pt_fall_cyc = 0;
  logic       prev_re_n = 1'b1;
  logic       prev_pt = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      gcyc++;
      if (!bus_we_n && !bus_re_n) viol++;
      if (!pad_t && !bus_re_n) viol++;
      if (!bus_re_n) re_gap = 0;
      else if (re_gap < 100) re_gap++;
      if (!pad_t && re_gap <= 2) viol++;
      if (bus_re_n && !prev_re_n) re_rise_cyc = gcyc;
      if (!pad_t && prev_pt) pt_fall_cyc = gcyc;
      if (done && !busy) viol++;
      prev_re_n = bus_re_n;
      prev_pt   = pad_t;

      if (reset) begin
        in_txn = 0;
      end else if (busy) begin
        if (!in_txn) begin
          in_txn = 1; cyc = 0; we_cnt = 0; re_cnt = 0; pt_cnt = 0;
          done_cnt = 0; done_at = 0; rd_at_done = 8'hxx; po_at_done = 8'hxx;
        end
        cyc++;
        if (!bus_we_n) we_cnt++;
        if (!bus_re_n) re_cnt++;
        if (!pad_t) pt_cnt++;
        if (done) begin
          done_cnt++; done_at = cyc; rd_at_done = rdata; po_at_done = pad_o;
        end
      end else if (in_txn) begin
        in_txn = 0;
        if (q.size() == 0) begin
          chk("unexpected_txn", 1, 0);
        end else begin
          e = q.pop_front();
          chk("busy_cycles", cyc, e.busy_cyc);
          chk("we_low_cycles", we_cnt, e.we_low);
          chk("re_low_cycles", re_cnt, e.re_low);
          chk("pad_t0_cycles", pt_cnt, e.pt0);
          chk("done_cycle", done_at, e.done_cyc);
          chk("done_count", done_cnt, 1);
          chk("rdata_at_done", int'(rd_at_done), int'(e.rdata_exp));
          chk("pad_o_at_done", int'(po_at_done), int'(e.pado_exp));
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk({nm, "_timeout"}, 1, 0);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    rd_req = v.rd; wr_req = v.wr; wdata = v.wd; pad_i = v.pi;
    q.push_back(v);
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    wait_idle("txn");
  endtask

  function automatic vec_t mkw(input logic [7:0] wd, input logic [7:0] rdx);
    vec_t v;
    v.rd = 0; v.wr = 1; v.wd = wd; v.pi = 8'h00;
    v.busy_cyc = 6; v.we_low = 2; v.re_low = 0; v.pt0 = 4; v.done_cyc = 5;
    v.rdata_exp = rdx; v.pado_exp = wd;
    return v;
  endfunction

  function automatic vec_t mkr(input bit wr, input logic [7:0] wd, input logic [7:0] pi,
                               input logic [7:0] pox);
    vec_t v;
    v.rd = 1; v.wr = wr; v.wd = wd; v.pi = pi;
    v.busy_cyc = 4; v.we_low = 0; v.re_low = 2; v.pt0 = 0; v.done_cyc = 3;
    v.rdata_exp = pi; v.pado_exp = pox;
    return v;
  endfunction

  initial begin
    bit ok;
    int gap;
    tbl[0] = mkw(8'hA5, 8'h00);
    tbl[1] = mkr(0, 8'h00, 8'h3C, 8'hA5);
    tbl[2] = mkr(1, 8'hFF, 8'hC3, 8'hA5);
    tbl[3] = mkw(8'h5A, 8'hC3);
    tbl[4] = mkr(0, 8'h00, 8'h00, 8'h5A);
    tbl[5] = mkw(8'h00, 8'h00);
    tbl[6] = mkw(8'hFF, 8'h00);
    tbl[7] = mkr(0, 8'h00, 8'h81, 8'hFF);

    // Reset with both requests present: everything must stay quiet.
    reset = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wdata = 8'h5C; pad_i = 8'hEE;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pad_t", pad_t, 1);
    chk("rst_we_n", bus_we_n, 1);
    chk("rst_re_n", bus_re_n, 1);
    chk("rst_pad_o", pad_o, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    @(posedge clk); #1;
    wr_req = 1'b0; rd_req = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_pad_t", pad_t, 1);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Write pulsed during a read: must be ignored entirely.
    @(posedge clk); #1;
    rd_req = 1'b1; pad_i = 8'h11;
    q.push_back(mkr(0, 8'h00, 8'h11, 8'hFF));
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(posedge clk); #1;
    wr_req = 1'b1; wdata = 8'h99;
    @(posedge clk); #1;
    wr_req = 1'b0;
    wait_idle("busy_req");
    repeat (8) @(negedge clk);
    chk("busy_req_no_extra", int'(busy), 0);
    chk("busy_req_pad_o", pad_o, 8'hFF);

    // Read followed by a write request held high across the turnaround.
    @(posedge clk); #1;
    rd_req = 1'b1; pad_i = 8'hE7;
    q.push_back(mkr(0, 8'h00, 8'hE7, 8'hFF));
    q.push_back(mkw(8'h3B, 8'hE7));
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b1; wdata = 8'h3B;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!pad_t) begin ok = 1; break; end
    end
    if (!ok) chk("b2b_write_start_timeout", 1, 0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    wait_idle("b2b");
    gap = pt_fall_cyc - re_rise_cyc;
    chk("b2b_turn_gap_ge2", int'(gap >= 2), 1);

    // Reset during the write strobe aborts the transaction.
    @(posedge clk); #1;
    wr_req = 1'b1; wdata = 8'h77;
    @(posedge clk); #1;
    wr_req = 1'b0;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!bus_we_n) begin ok = 1; break; end
    end
    if (!ok) chk("abort_strobe_timeout", 1, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pad_t", pad_t, 1);
    chk("abort_we_n", bus_we_n, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rdata", rdata, 8'h00);
    chk("abort_pad_o", pad_o, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    ok = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) ok = 0;
    end
    chk("abort_quiet_after", int'(ok), 1);

    chk("scoreboard_empty", q.size(), 0);
    chk("bus_invariants", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tristate_bus_ctrl.md
TRISTATE_BUS_CTRL -- requirements
Module: tristate_bus_ctrl

Interface
REQ-001 The block SHALL have parameter SETUP_CYCLES, default 1: cycles data is driven before the write strobe.
REQ-002 The block SHALL have parameter STROBE_CYCLES, default 2: strobe low width for both reads and writes.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 1: cycles data stays driven after the write strobe rises.
REQ-004 The block SHALL have parameter TURN_CYCLES, default 2: bus-released gap closing every transaction.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 The block SHALL have port wr_req, input, 1 bit: write request, sampled only in IDLE.
REQ-008 The block SHALL have port rd_req, input, 1 bit: read request, sampled only in IDLE.
REQ-009 The block SHALL have port wdata, input, 8 bits: write data, captured on write acceptance.
REQ-010 The block SHALL have port rdata, output, 8 bits: last registered read data.
REQ-011 The block SHALL have port busy, output, 1 bit: transaction in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port pad_o, output, 8 bits: data to the pad buffer I inputs.
REQ-014 The block SHALL have port pad_t, output, 1 bit: pad tristate control, 1 = high-impedance.
REQ-015 The block SHALL have port pad_i, input, 8 bits: data from the pad buffer O outputs.
REQ-016 The block SHALL have ports bus_we_n and bus_re_n, output, 1 bit each: active-low external strobes.

Function
REQ-017 The block SHALL implement states IDLE, WSETUP, WSTROBE, WHOLD, RSTROBE and TURN, with all outputs registered.
REQ-018 The block SHALL use a 4-bit down-counter for phase lengths; legal parameter range is 1..15.
REQ-019 In IDLE, rd_req=1 SHALL move to RSTROBE; otherwise wr_req=1 SHALL latch wdata into pad_o and move to WSETUP.
REQ-020 When rd_req and wr_req are asserted together, the read SHALL win and the write SHALL be dropped.
REQ-021 busy SHALL be 1 in every state except IDLE; it rises the cycle after acceptance.
REQ-022 Requests arriving while busy=1 SHALL be ignored, not queued.
REQ-023 In WSETUP the block SHALL drive pad_t=0 and bus_we_n=1 for SETUP_CYCLES, then go to WSTROBE.
REQ-024 In WSTROBE the block SHALL drive pad_t=0 and bus_we_n=0 for STROBE_CYCLES, then go to WHOLD.
REQ-025 In WHOLD the block SHALL drive pad_t=0 and bus_we_n=1 for HOLD_CYCLES, then go to TURN.
REQ-026 In RSTROBE the block SHALL drive pad_t=1 and bus_re_n=0 for STROBE_CYCLES.
REQ-027 At the clock edge ending the last RSTROBE cycle, the block SHALL register pad_i into rdata and go to TURN.
REQ-028 In TURN the block SHALL drive pad_t=1 with both strobes high for TURN_CYCLES, then return to IDLE.
REQ-029 done SHALL pulse exactly in the first TURN cycle; for reads, rdata is valid in that cycle.
REQ-030 rdata SHALL hold its value until the next read completes.
REQ-031 pad_t SHALL never be 0 while bus_re_n=0, and SHALL never be 0 within TURN_CYCLES after a read strobe rises.
REQ-032 bus_we_n and bus_re_n SHALL never be low simultaneously.
REQ-033 In IDLE the block SHALL drive pad_t=1 with both strobes high; pad_o keeps its last value.
REQ-034 With defaults, a write SHALL occupy 6 busy cycles: WSETUP 1, WSTROBE 2, WHOLD 1, TURN 2.
REQ-035 With defaults, a read SHALL occupy 4 busy cycles: RSTROBE 2, TURN 2.

Reset
REQ-036 While reset=1, the block SHALL hold state=IDLE, pad_t=1, bus_we_n=1, bus_re_n=1, pad_o=0x00, rdata=0x00, busy=0, done=0.
REQ-037 A reset asserted mid-transaction SHALL abort the transaction: pad_t=1 and both strobes are high from the first clock edge with reset=1, and no done pulse is issued.
REQ-038 reset SHALL take priority over requests, so wr_req or rd_req present during reset is ignored.

Verification
REQ-039 Scenario -- write: defaults, wr_req 1 cycle with wdata=0xA5 -> pad_t=0 for 4 cycles, pad_o=0xA5, bus_we_n low in cycles 2-3 after acceptance, done in cycle 5, busy low in cycle 7.
REQ-040 Scenario -- read: pad_i=0x3C, rd_req 1 cycle -> bus_re_n low 2 cycles with pad_t=1, done with rdata=0x3C the next cycle, busy cycles=4.
REQ-041 Scenario -- simultaneous requests: wr_req=rd_req=1 -> read only, bus_we_n never low, pad_t stays 1.
REQ-042 Scenario -- request while busy: wr_req pulsed during a read -> ignored, exactly one done pulse.
REQ-043 Scenario -- back-to-back turnaround: read, then wr_req held high -> pad_t=0 no earlier than 2 cycles after bus_re_n rises.
REQ-044 Scenario -- reset mid-operation: reset during WSTROBE -> next cycle pad_t=1, bus_we_n=1, busy=0, no done, rdata=0x00.
